// File: rtl/bus_arbiter_if.sv
// Request/response bundle between the two bus masters, the arbiter and the memory port.
// The master modport is the requester/memory side; the slave modport is the arbiter's view.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m0_req;
  logic [ADDR_W-1:0]     m0_addr;
  logic                  m0_we;
  logic [DATA_W/8-1:0]   m0_be;
  logic [DATA_W-1:0]     m0_wdata;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_req;
  logic [ADDR_W-1:0]     m1_addr;
  logic                  m1_we;
  logic [DATA_W/8-1:0]   m1_be;
  logic [DATA_W-1:0]     m1_wdata;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_W-1:0]     m1_rdata;

  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  owner;
  logic                  busy;

  modport master (
    output m0_req, m0_addr, m0_we, m0_be, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_addr, m1_we, m1_be, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_ack, mem_rdata,
    input  owner, busy
  );

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_be, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_addr, m1_we, m1_be, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_ack, mem_rdata,
    output owner, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory port with a hung-transaction timeout.
// One transaction in flight at a time; the completion is routed back to the owning master.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave io_bus
);
  localparam int               BE_W       = DATA_W / 8;
  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
  localparam logic             LP_TO_EN   = (TIMEOUT != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_served;
  logic                r_owner;
  logic                r_busy;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_grant_vld;
  logic                w_grant_sel;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_we;
  logic [BE_W-1:0]     w_sel_be;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_timeout;
  logic                w_done;
  logic                w_m0_ack;
  logic                w_m0_err;
  logic [DATA_W-1:0]   w_m0_rdata;
  logic                w_m1_ack;
  logic                w_m1_err;
  logic [DATA_W-1:0]   w_m1_rdata;

  // Winner selection: a lone requester wins, contention goes to the master not served last
  always_comb begin
    w_grant_vld = io_bus.m0_req | io_bus.m1_req;
    if (io_bus.m0_req && io_bus.m1_req) begin
      w_grant_sel = ~r_last_served;
    end else if (io_bus.m1_req) begin
      w_grant_sel = 1'b1;
    end else begin
      w_grant_sel = 1'b0;
    end
  end

  // Command mux of the winning master
  always_comb begin
    if (w_grant_sel) begin
      w_sel_addr  = io_bus.m1_addr;
      w_sel_we    = io_bus.m1_we;
      w_sel_be    = io_bus.m1_be;
      w_sel_wdata = io_bus.m1_wdata;
    end else begin
      w_sel_addr  = io_bus.m0_addr;
      w_sel_we    = io_bus.m0_we;
      w_sel_be    = io_bus.m0_be;
      w_sel_wdata = io_bus.m0_wdata;
    end
  end

  // A real mem_ack always beats an abort landing in the same cycle
  assign w_timeout = LP_TO_EN && (r_cnt == LP_TIMEOUT) && !io_bus.mem_ack;
  assign w_done    = (r_state == ST_BUSY) && (io_bus.mem_ack || w_timeout);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, ownership, round-robin history and the hang counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_served <= 1'b1;
      r_owner       <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= {ADDR_W{1'b0}};
      r_mem_we      <= 1'b0;
      r_mem_be      <= {BE_W{1'b0}};
      r_mem_wdata   <= {DATA_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_we    <= w_sel_we;
            r_mem_be    <= w_sel_be;
            r_mem_wdata <= w_sel_wdata;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_owner     <= w_grant_sel;
            r_cnt       <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_mem_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_last_served <= r_owner;
          end else if (r_cnt != LP_CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Completion routing: only the owner sees ack/err/rdata, everything else reads zero
  always_comb begin
    w_m0_ack   = 1'b0;
    w_m0_err   = 1'b0;
    w_m0_rdata = {DATA_W{1'b0}};
    w_m1_ack   = 1'b0;
    w_m1_err   = 1'b0;
    w_m1_rdata = {DATA_W{1'b0}};
    if (w_done) begin
      if (r_owner) begin
        w_m1_ack   = 1'b1;
        w_m1_err   = w_timeout;
        w_m1_rdata = w_timeout ? {DATA_W{1'b0}} : io_bus.mem_rdata;
      end else begin
        w_m0_ack   = 1'b1;
        w_m0_err   = w_timeout;
        w_m0_rdata = w_timeout ? {DATA_W{1'b0}} : io_bus.mem_rdata;
      end
    end else begin
      w_m0_ack = 1'b0;
      w_m1_ack = 1'b0;
    end
  end

  assign io_bus.m0_ack    = w_m0_ack;
  assign io_bus.m0_err    = w_m0_err;
  assign io_bus.m0_rdata  = w_m0_rdata;
  assign io_bus.m1_ack    = w_m1_ack;
  assign io_bus.m1_err    = w_m1_err;
  assign io_bus.m1_rdata  = w_m1_rdata;
  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_be    = r_mem_be;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.owner     = r_owner;
  assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed table and corner sequences, then randomized traffic
// checked against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bif)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_owner;
    logic        e_m0_ack;
    logic        e_m1_ack;
    logic [31:0] e_mem_addr;
    logic [31:0] e_m0_rdata;
    logic [31:0] e_m1_rdata;
  } vec_t;
  vec_t tbl [8];

  // Reference model: the single outstanding transaction and who gets the bus next
  logic          md_busy;
  logic          md_owner;
  logic          md_last;
  int            md_age;
  logic [AW-1:0] md_addr;
  logic          md_we;
  logic [3:0]    md_be;
  logic [DW-1:0] md_wdata;
  logic          md_done [2];

  logic          drv_req   [2];
  logic [AW-1:0] drv_addr  [2];
  logic          drv_we    [2];
  logic [3:0]    drv_be    [2];
  logic [DW-1:0] drv_wdata [2];

  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_busy    <= 1'b0;
      md_owner   <= 1'b0;
      md_last    <= 1'b1;
      md_age     <= 0;
      md_addr    <= '0;
      md_we      <= 1'b0;
      md_be      <= 4'h0;
      md_wdata   <= '0;
      md_done[0] <= 1'b0;
      md_done[1] <= 1'b0;
    end else begin
      md_done[0] <= 1'b0;
      md_done[1] <= 1'b0;
      if (md_busy) begin
        if (bif.mem_ack || md_age == TO) begin
          md_done[md_owner] <= 1'b1;
          md_last           <= md_owner;
          md_busy           <= 1'b0;
        end else begin
          md_age <= md_age + 1;
        end
      end else if (bif.m0_req || bif.m1_req) begin
        md_busy  <= 1'b1;
        md_age   <= 0;
        md_owner <= rr_pick(bif.m0_req, bif.m1_req, md_last);
        if (rr_pick(bif.m0_req, bif.m1_req, md_last)) begin
          md_addr <= bif.m1_addr; md_we <= bif.m1_we; md_be <= bif.m1_be; md_wdata <= bif.m1_wdata;
        end else begin
          md_addr <= bif.m0_addr; md_we <= bif.m0_we; md_be <= bif.m0_be; md_wdata <= bif.m0_wdata;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.m0_req = 1'b0; bif.m0_addr = '0; bif.m0_we = 1'b0; bif.m0_be = 4'h0; bif.m0_wdata = '0;
    bif.m1_req = 1'b0; bif.m1_addr = '0; bif.m1_we = 1'b0; bif.m1_be = 4'h0; bif.m1_wdata = '0;
    bif.mem_ack = 1'b0; bif.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic model_check();
    logic          fin;
    logic          err;
    logic          e_ack [2];
    logic [DW-1:0] e_rd  [2];
    fin = md_busy && (bif.mem_ack || md_age == TO);
    err = fin && !bif.mem_ack;
    for (int i = 0; i < 2; i++) begin
      e_ack[i] = fin && (int'(md_owner) == i);
      e_rd[i]  = (e_ack[i] && !err) ? bif.mem_rdata : '0;
    end
    chk("rnd_mem_req", bif.mem_req, md_busy);
    chk("rnd_busy", bif.busy, md_busy);
    if (md_busy) chk("rnd_owner", bif.owner, md_owner);
    chk("rnd_mem_cmd", {bif.mem_addr, bif.mem_we, bif.mem_be, bif.mem_wdata},
        {md_addr, md_we, md_be, md_wdata});
    chk("rnd_m0_resp", {bif.m0_ack, bif.m0_err, bif.m0_rdata}, {e_ack[0], e_ack[0] && err, e_rd[0]});
    chk("rnd_m1_resp", {bif.m1_ack, bif.m1_err, bif.m1_rdata}, {e_ack[1], e_ack[1] && err, e_rd[1]});
  endtask

  initial begin
    // Contention from reset against a zero-wait memory: M0, M1, M0, M1 with an idle cycle between
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h1001, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA000, 32'h1001, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h1002, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA000, 32'h0,    32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h1003, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB000, 32'h0,    32'h1003};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB000, 32'h0,    32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h1005, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA000, 32'h1005, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h1006, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA000, 32'h0,    32'h0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h1007, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB000, 32'h0,    32'h1007};

    do_reset();
    @(negedge clk);
    chk("rst_mem_req", bif.mem_req, 1'b0);
    chk("rst_busy", bif.busy, 1'b0);
    chk("rst_owner", bif.owner, 1'b0);
    chk("rst_mem_cmd", {bif.mem_addr, bif.mem_we, bif.mem_be, bif.mem_wdata}, 69'h0);
    chk("rst_acks", {bif.m0_ack, bif.m0_err, bif.m1_ack, bif.m1_err}, 4'h0);
    nxt();

    bif.m0_addr = 32'hA000;
    bif.m1_addr = 32'hB000;
    for (int i = 0; i < 8; i++) begin
      bif.m0_req = tbl[i].m0_req; bif.m1_req = tbl[i].m1_req;
      bif.mem_ack = tbl[i].mem_ack; bif.mem_rdata = tbl[i].mem_rdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_req", i), bif.mem_req, tbl[i].e_mem_req);
      chk($sformatf("tbl%0d_busy", i), bif.busy, tbl[i].e_mem_req);
      if (tbl[i].e_mem_req) chk($sformatf("tbl%0d_owner", i), bif.owner, tbl[i].e_owner);
      chk($sformatf("tbl%0d_acks", i), {bif.m0_ack, bif.m1_ack}, {tbl[i].e_m0_ack, tbl[i].e_m1_ack});
      chk($sformatf("tbl%0d_mem_addr", i), bif.mem_addr, tbl[i].e_mem_addr);
      chk($sformatf("tbl%0d_rdata", i), {bif.m0_rdata, bif.m1_rdata}, {tbl[i].e_m0_rdata, tbl[i].e_m1_rdata});
      nxt();
    end
    clear_inputs();
    @(negedge clk);
    nxt();

    // Single read, memory acks two cycles after mem_req
    bif.m0_req = 1'b1; bif.m0_addr = 32'h100; bif.m0_we = 1'b0; bif.m0_be = 4'hF;
    @(negedge clk);
    chk("rd_idle_mem_req", bif.mem_req, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 3) begin bif.mem_ack = 1'b1; bif.mem_rdata = 32'hDEADBEEF; end
      @(negedge clk);
      chk($sformatf("rd_c%0d_mem_req", k), bif.mem_req, 1'b1);
      chk($sformatf("rd_c%0d_cmd", k), {bif.mem_addr, bif.mem_we}, {32'h100, 1'b0});
      chk($sformatf("rd_c%0d_m0", k), {bif.m0_ack, bif.m0_err, bif.m0_rdata},
          (k == 3) ? {1'b1, 1'b0, 32'hDEADBEEF} : 34'h0);
      chk($sformatf("rd_c%0d_m1_ack", k), bif.m1_ack, 1'b0);
    end
    nxt();
    bif.m0_req = 1'b0; bif.mem_ack = 1'b0; bif.mem_rdata = '0;
    @(negedge clk);
    chk("rd_end_state", {bif.mem_req, bif.busy, bif.m0_ack}, 3'b000);

    // Write pass-through from M1; its inputs are scrambled and req dropped while granted
    nxt();
    bif.m1_req = 1'b1; bif.m1_addr = 32'h2004; bif.m1_we = 1'b1; bif.m1_be = 4'b0011; bif.m1_wdata = 32'h0000ABCD;
    @(negedge clk);
    chk("wr_idle_mem_req", bif.mem_req, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      if (k == 2) begin
        bif.m1_req = 1'b0; bif.m1_addr = 32'hFFFFFFFF; bif.m1_we = 1'b0; bif.m1_be = 4'hF; bif.m1_wdata = 32'hFFFFFFFF;
      end
      if (k == 4) bif.mem_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("wr_c%0d_cmd", k), {bif.mem_req, bif.mem_addr, bif.mem_we, bif.mem_be, bif.mem_wdata},
          {1'b1, 32'h2004, 1'b1, 4'b0011, 32'h0000ABCD});
      chk($sformatf("wr_c%0d_owner", k), bif.owner, 1'b1);
      chk($sformatf("wr_c%0d_acks", k), {bif.m0_ack, bif.m1_ack, bif.m1_err}, {1'b0, (k == 4), 1'b0});
    end
    nxt();
    bif.mem_ack = 1'b0;
    @(negedge clk);
    chk("wr_end_state", {bif.mem_req, bif.busy, bif.m1_ack}, 3'b000);

    // Timeout: memory never acks, then a later M1 request is still served
    nxt();
    bif.m0_req = 1'b1; bif.m0_addr = 32'h300; bif.m0_we = 1'b0; bif.mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      @(negedge clk);
      chk($sformatf("to_c%0d_mem_req", k), bif.mem_req, 1'b1);
      chk($sformatf("to_c%0d_m0", k), {bif.m0_ack, bif.m0_err, bif.m0_rdata},
          (k == 5) ? {1'b1, 1'b1, 32'h0} : 34'h0);
      chk($sformatf("to_c%0d_m1_ack", k), bif.m1_ack, 1'b0);
    end
    nxt();
    bif.m0_req = 1'b0; bif.m1_req = 1'b1; bif.m1_addr = 32'h600; bif.m1_we = 1'b0;
    @(negedge clk);
    chk("to_idle", {bif.mem_req, bif.busy, bif.m0_ack, bif.m0_err}, 4'h0);
    nxt();
    bif.mem_ack = 1'b1; bif.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("to_m1_grant", {bif.mem_req, bif.owner, bif.mem_addr}, {1'b1, 1'b1, 32'h600});
    chk("to_m1_resp", {bif.m1_ack, bif.m1_err, bif.m1_rdata}, {1'b1, 1'b0, 32'h12345678});
    nxt();
    bif.m1_req = 1'b0; bif.mem_ack = 1'b0;

    // Stray mem_ack while idle
    nxt();
    bif.mem_ack = 1'b1;
    @(negedge clk);
    chk("stray_acks", {bif.mem_req, bif.busy, bif.m0_ack, bif.m1_ack}, 4'h0);
    nxt();
    bif.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_after", {bif.mem_req, bif.busy}, 2'b00);

    // Reset in the middle of a transaction
    nxt();
    bif.m0_req = 1'b1; bif.m0_addr = 32'h400;
    nxt();
    @(negedge clk);
    chk("rmid_busy", {bif.mem_req, bif.busy}, 2'b11);
    #1 rst = 1'b0;
    #1;
    chk("rmid_async_drop", {bif.mem_req, bif.busy, bif.m0_ack, bif.m1_ack}, 4'h0);
    bif.m0_req = 1'b0;
    nxt();
    chk("rmid_in_reset", {bif.mem_req, bif.m0_ack}, 2'b00);
    rst = 1'b1; bif.m1_req = 1'b1; bif.m1_addr = 32'h500;
    @(negedge clk);
    chk("rmid_release", {bif.mem_req, bif.m0_ack, bif.m1_ack}, 3'b000);
    nxt();
    bif.mem_ack = 1'b1; bif.mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    chk("rmid_m1_grant", {bif.mem_req, bif.owner, bif.mem_addr}, {1'b1, 1'b1, 32'h500});
    chk("rmid_m1_ack", {bif.m1_ack, bif.m1_rdata, bif.m0_ack}, {1'b1, 32'hCAFE0001, 1'b0});
    nxt();
    clear_inputs();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drv_req[i] = 1'b0; drv_addr[i] = '0; drv_we[i] = 1'b0; drv_be[i] = 4'h0; drv_wdata[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!drv_req[i] || md_done[i]) begin
          drv_req[i] = ($urandom_range(0, 9) < 5);
          if (drv_req[i]) begin
            drv_addr[i]  = $urandom();
            drv_we[i]    = 1'($urandom_range(0, 1));
            drv_be[i]    = 4'($urandom_range(0, 15));
            drv_wdata[i] = $urandom();
          end
        end
      end
      bif.m0_req = drv_req[0]; bif.m0_addr = drv_addr[0]; bif.m0_we = drv_we[0];
      bif.m0_be = drv_be[0]; bif.m0_wdata = drv_wdata[0];
      bif.m1_req = drv_req[1]; bif.m1_addr = drv_addr[1]; bif.m1_we = drv_we[1];
      bif.m1_be = drv_be[1]; bif.m1_wdata = drv_wdata[1];
      bif.mem_ack = ($urandom_range(0, 9) < 3);
      bif.mem_rdata = $urandom();
      @(negedge clk);
      model_check();
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
